// File: rtl/fetch_ctrl.sv
// Instruction fetch controller.
// Issues one instruction-memory request at a time, presents fetched words to
// decode through a registered output stage backed by a one-entry skid buffer,
// and handles branch/exception redirects, including redirects that arrive while
// a request is still outstanding (the stale word is drained and discarded).
// A misaligned fetch address is reported to decode as an address-error word.
module fetch_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hbfc0_0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        exc_req,
    input  logic [31:0] exc_pc,
    input  logic        br_req,
    input  logic [31:0] br_target,
    input  logic        id_stall,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ack,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_inst,
    output logic [31:0] if_pc,
    output logic        if_adel
);

    // FETCH : request at pc, output/skid accept the returned word
    // FULL  : output and skid both occupied, no request until decode consumes
    // DRAIN : a redirected-away request is still outstanding; its word is dropped
    // ERR   : pc is misaligned; the address-error word is held for decode
    typedef enum logic [1:0] {
        S_FETCH = 2'd0,
        S_FULL  = 2'd1,
        S_DRAIN = 2'd2,
        S_ERR   = 2'd3
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] pc_q, pc_d;            // address of the current/next request
    logic [31:0] tgt_q, tgt_d;          // redirect target saved while draining

    logic        out_valid_q, out_valid_d;
    logic [31:0] out_inst_q, out_inst_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        out_adel_q, out_adel_d;

    logic [31:0] skid_inst_q, skid_inst_d;
    logic [31:0] skid_pc_q, skid_pc_d;

    logic        redirect;
    logic [31:0] redir_tgt;
    logic        consumed;
    logic        out_free;
    logic        pc_misaligned;
    logic        acked;

    // Exception redirects win over branch redirects.
    assign redirect      = exc_req | br_req;
    assign redir_tgt     = exc_req ? exc_pc : br_target;

    // Decode takes the presented word whenever it is valid and not stalled.
    assign consumed      = out_valid_q & ~id_stall;
    assign out_free      = ~out_valid_q | consumed;
    assign pc_misaligned = (pc_q[1:0] != 2'b00);
    assign acked         = imem_req & imem_ack;

    // pc is held unchanged while draining, so it is always the live request address.
    assign imem_addr     = pc_q;

    assign if_valid      = out_valid_q;
    assign if_inst       = out_inst_q;
    assign if_pc         = out_pc_q;
    assign if_adel       = out_adel_q;

    // Request is driven from state only; reset forces it low immediately.
    always_comb begin
        imem_req = 1'b0;
        if (!reset) begin
            unique case (state_q)
                S_FETCH: imem_req = ~pc_misaligned;
                S_DRAIN: imem_req = 1'b1;
                S_FULL:  imem_req = 1'b0;
                S_ERR:   imem_req = 1'b0;
                default: imem_req = 1'b0;
            endcase
        end
    end

    // Next-state, pc and output/skid register update.
    always_comb begin
        // NOTE: every next-state signal takes its current value first, so any
        // path that does not assign it simply holds -- no latch is inferred.
        state_d     = state_q;
        pc_d        = pc_q;
        tgt_d       = tgt_q;
        out_valid_d = out_valid_q;
        out_inst_d  = out_inst_q;
        out_pc_d    = out_pc_q;
        out_adel_d  = out_adel_q;
        skid_inst_d = skid_inst_q;
        skid_pc_d   = skid_pc_q;

        // A consumed word leaves the output stage, except the address-error
        // word, which stays presented until a redirect.
        if (state_q != S_ERR && consumed) begin
            out_valid_d = 1'b0;
        end

        if (redirect) begin
            // Flush everything queued for decode; skid occupancy is implied by
            // FULL, which is left here.
            out_valid_d = 1'b0;
            out_adel_d  = 1'b0;
            skid_inst_d = 32'h0;
            skid_pc_d   = 32'h0;
            if (imem_req && !imem_ack) begin
                // The request cannot be withdrawn: keep pc on it and drain.
                tgt_d   = redir_tgt;
                state_d = S_DRAIN;
            end else begin
                // Nothing outstanding (any word acked this cycle is dropped).
                pc_d    = redir_tgt;
                state_d = S_FETCH;
            end
        end else begin
            unique case (state_q)
                S_FETCH: begin
                    if (pc_misaligned) begin
                        if (out_free) begin
                            out_valid_d = 1'b1;
                            out_inst_d  = 32'h0;
                            out_pc_d    = pc_q;
                            out_adel_d  = 1'b1;
                            state_d     = S_ERR;
                        end
                    end else if (acked) begin
                        if (out_free) begin
                            out_valid_d = 1'b1;
                            out_inst_d  = imem_rdata;
                            out_pc_d    = pc_q;
                            out_adel_d  = 1'b0;
                        end else begin
                            skid_inst_d = imem_rdata;
                            skid_pc_d   = pc_q;
                            state_d     = S_FULL;
                        end
                        pc_d = pc_q + 32'd4;
                    end
                end
                S_FULL: begin
                    if (consumed) begin
                        out_valid_d = 1'b1;
                        out_inst_d  = skid_inst_q;
                        out_pc_d    = skid_pc_q;
                        out_adel_d  = 1'b0;
                        state_d     = S_FETCH;
                    end
                end
                S_DRAIN: begin
                    if (imem_ack) begin
                        pc_d    = tgt_q;
                        state_d = S_FETCH;
                    end
                end
                S_ERR: begin
                    state_d = S_ERR;
                end
                default: begin
                    state_d = S_FETCH;
                end
            endcase
        end
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        // NOTE: registers use non-blocking assignments so every flop samples
        // the pre-edge values regardless of statement order.
        if (reset) begin
            state_q     <= S_FETCH;
            pc_q        <= RESET_PC;
            tgt_q       <= 32'h0;
            out_valid_q <= 1'b0;
            out_inst_q  <= 32'h0;
            out_pc_q    <= 32'h0;
            out_adel_q  <= 1'b0;
            skid_inst_q <= 32'h0;
            skid_pc_q   <= 32'h0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            tgt_q       <= tgt_d;
            out_valid_q <= out_valid_d;
            out_inst_q  <= out_inst_d;
            out_pc_q    <= out_pc_d;
            out_adel_q  <= out_adel_d;
            skid_inst_q <= skid_inst_d;
            skid_pc_q   <= skid_pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_ctrl.sv
// Testbench for fetch_ctrl: directed scenarios followed by random traffic,
// checked against a queue-based transaction model of the fetch stream.
module tb_fetch_ctrl;

    localparam logic [31:0] RESET_PC = 32'hbfc0_0000;

    logic        clk;
    logic        reset;
    logic        exc_req;
    logic [31:0] exc_pc;
    logic        br_req;
    logic [31:0] br_target;
    logic        id_stall;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        if_valid;
    logic [31:0] if_inst;
    logic [31:0] if_pc;
    logic        if_adel;

    int errors = 0;
    int checks = 0;

    fetch_ctrl #(.RESET_PC(RESET_PC)) dut (
        .clk        (clk),
        .reset      (reset),
        .exc_req    (exc_req),
        .exc_pc     (exc_pc),
        .br_req     (br_req),
        .br_target  (br_target),
        .id_stall   (id_stall),
        .imem_req   (imem_req),
        .imem_addr  (imem_addr),
        .imem_ack   (imem_ack),
        .imem_rdata (imem_rdata),
        .if_valid   (if_valid),
        .if_inst    (if_inst),
        .if_pc      (if_pc),
        .if_adel    (if_adel)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Memory contents: a fixed scramble of the address.
    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9bdf;
    endfunction

    assign imem_rdata = imem_ack ? mem_word(imem_addr) : 32'hdead_beef;

    // ---------------- reference model ----------------
    // Words fetched but not yet consumed by decode, oldest first.
    logic [31:0] mq_pc[$];
    logic [31:0] mq_inst[$];
    logic [31:0] m_next;      // address of the next useful fetch
    logic [31:0] m_kill;      // address of an outstanding, abandoned request
    bit          m_drain;     // an abandoned request is still outstanding
    bit          m_err;       // address-error word is being presented

    function automatic bit m_req();
        return !reset && (m_drain || (!m_err && mq_pc.size() < 2 && m_next[1:0] == 2'b00));
    endfunction

    function automatic logic [31:0] m_addr();
        return m_drain ? m_kill : m_next;
    endfunction

    // Advance the model across one rising edge using the pre-edge inputs.
    task automatic model_update();
        bit          req_now;
        logic [31:0] cur_addr;
        req_now  = m_req();
        cur_addr = m_addr();
        if (reset) begin
            mq_pc.delete();
            mq_inst.delete();
            m_next  = RESET_PC;
            m_drain = 1'b0;
            m_err   = 1'b0;
        end else if (exc_req || br_req) begin
            mq_pc.delete();
            mq_inst.delete();
            m_err = 1'b0;
            if (req_now && !imem_ack) begin
                m_drain = 1'b1;
                m_kill  = cur_addr;
            end else begin
                m_drain = 1'b0;
            end
            m_next = exc_req ? exc_pc : br_target;
        end else if (m_drain) begin
            if (imem_ack) m_drain = 1'b0;
        end else if (!m_err) begin
            if (mq_pc.size() > 0 && !id_stall) begin
                void'(mq_pc.pop_front());
                void'(mq_inst.pop_front());
            end
            if (m_next[1:0] != 2'b00) begin
                if (mq_pc.size() == 0) m_err = 1'b1;
            end else if (req_now && imem_ack) begin
                mq_pc.push_back(m_next);
                mq_inst.push_back(mem_word(m_next));
                m_next = m_next + 32'd4;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            errors++;
            $error("FAIL %s: observed=%h expected=%h", tag, got, exp);
        end
    endtask

    task automatic check_outputs();
        check("imem_req", {31'h0, imem_req}, {31'h0, m_req()});
        if (m_req()) check("imem_addr", imem_addr, m_addr());
        if (m_err) begin
            check("err_valid", {31'h0, if_valid}, 32'h1);
            check("err_adel", {31'h0, if_adel}, 32'h1);
            check("err_pc", if_pc, m_next);
            check("err_inst", if_inst, 32'h0);
        end else begin
            check("if_valid", {31'h0, if_valid}, {31'h0, mq_pc.size() > 0});
            check("if_adel", {31'h0, if_adel}, 32'h0);
            if (mq_pc.size() > 0) begin
                check("if_pc", if_pc, mq_pc[0]);
                check("if_inst", if_inst, mq_inst[0]);
            end
        end
    endtask

    // One clock cycle: memory acks a live request when ack_ok is set.
    task automatic step(input bit ack_ok);
        imem_ack = imem_req && ack_ok;
        model_update();
        @(posedge clk);
        #1;
        check_outputs();
    endtask

    task automatic check_reset_values();
        check("rst_req", {31'h0, imem_req}, 32'h0);
        check("rst_valid", {31'h0, if_valid}, 32'h0);
        check("rst_inst", if_inst, 32'h0);
        check("rst_pc", if_pc, 32'h0);
        check("rst_adel", {31'h0, if_adel}, 32'h0);
    endtask

    initial begin
        logic [31:0] t;
        int          r;
        reset     = 1'b1;
        exc_req   = 1'b0;
        exc_pc    = 32'h0;
        br_req    = 1'b0;
        br_target = 32'h0;
        id_stall  = 1'b0;
        imem_ack  = 1'b0;
        m_next    = RESET_PC;
        m_kill    = 32'h0;
        m_drain   = 1'b0;
        m_err     = 1'b0;
        #1;

        // Reset values.
        step(1'b0);
        step(1'b0);
        check_reset_values();

        // Release: sequential fetch at one instruction per cycle.
        reset = 1'b0;
        #1;
        check("rel_req", {31'h0, imem_req}, 32'h1);
        check("rel_addr", imem_addr, 32'hbfc0_0000);
        step(1'b1);
        check("seq_addr1", imem_addr, 32'hbfc0_0004);
        check("seq_pc0", if_pc, 32'hbfc0_0000);
        step(1'b1);
        check("seq_addr2", imem_addr, 32'hbfc0_0008);
        check("seq_pc1", if_pc, 32'hbfc0_0004);

        // Decode stall while an ack arrives: word parks in the skid register.
        id_stall = 1'b1;
        step(1'b1);
        check("full_req", {31'h0, imem_req}, 32'h0);
        step(1'b1);
        step(1'b1);
        id_stall = 1'b0;
        for (int i = 0; i < 4; i++) step(1'b1);

        // Branch while request to bfc0_0008 is unacked: drain, then redirect.
        reset = 1'b1;
        step(1'b0);
        reset = 1'b0;
        step(1'b1);
        step(1'b1);
        check("pre_br_addr", imem_addr, 32'hbfc0_0008);
        br_req    = 1'b1;
        br_target = 32'h8000_0100;
        step(1'b0);
        br_req = 1'b0;
        step(1'b0);
        step(1'b1);
        check("drain_addr", imem_addr, 32'h8000_0100);
        check("drain_valid", {31'h0, if_valid}, 32'h0);

        // Exception and branch together: exception wins.
        exc_req   = 1'b1;
        exc_pc    = 32'hbfc0_0380;
        br_req    = 1'b1;
        br_target = 32'h1234_0000;
        step(1'b1);
        exc_req = 1'b0;
        br_req  = 1'b0;
        check("exc_addr", imem_addr, 32'hbfc0_0380);
        check("exc_valid", {31'h0, if_valid}, 32'h0);

        // Misaligned branch target: address error held until an exception.
        br_req    = 1'b1;
        br_target = 32'h8000_0102;
        step(1'b1);
        br_req = 1'b0;
        check("adel_noreq", {31'h0, imem_req}, 32'h0);
        step(1'b0);
        step(1'b0);
        id_stall = 1'b1;
        step(1'b0);
        id_stall = 1'b0;
        check("adel_flag", {31'h0, if_adel}, 32'h1);
        check("adel_pc", if_pc, 32'h8000_0102);
        exc_req = 1'b1;
        exc_pc  = 32'hbfc0_0380;
        step(1'b0);
        exc_req = 1'b0;
        check("resume_addr", imem_addr, 32'hbfc0_0380);

        // Reset while draining.
        br_req    = 1'b1;
        br_target = 32'h8000_0200;
        step(1'b0);
        br_req = 1'b0;
        reset  = 1'b1;
        step(1'b0);
        check_reset_values();
        reset = 1'b0;
        #1;
        check("rst_drain_addr", imem_addr, RESET_PC);

        // Random traffic.
        for (int n = 0; n < 800; n++) begin
            id_stall = ($urandom_range(0, 3) == 0);
            r        = $urandom_range(0, 19);
            br_req   = (r < 2);
            exc_req  = (r == 2) || (r == 1 && $urandom_range(0, 1) == 1);
            t        = $urandom & 32'hffff_fffc;
            if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
            br_target = t;
            t         = $urandom & 32'hffff_fffc;
            if ($urandom_range(0, 7) == 0) t[1:0] = 2'($urandom_range(1, 3));
            exc_pc = t;
            reset  = ($urandom_range(0, 99) == 0);
            step($urandom_range(0, 2) != 0);
        end
        reset   = 1'b0;
        br_req  = 1'b0;
        exc_req = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
